// File: rtl/skolem_ic_sweep_ctrl.sv
// Sweep controller and checker for the bvugt-over-bvshl invertibility condition:
// walks every {t,s} vector, compares the FUT bit to t <u (ONES << s). Optional: SKOLEM_STOP_ON_FAIL_EN.
module skolem_ic_sweep_ctrl #(
  parameter int W   = 4,
  parameter int LAT = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [2*W-1:0] fut_in,
  input  logic           fut_out,
  output logic           busy,
  output logic           done,
  output logic [2*W:0]   fail_cnt,
  output logic [2*W-1:0] first_fail,
  output logic           fail_seen
);

  localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic [W-1:0]  s_op, t_op, mask;
  logic          golden, mismatch, last_vec, wait_end;

  // Golden is derived from the registered vector only, so FUT timing cannot leak into it.
  assign s_op     = fut_in[W-1:0];
  assign t_op     = fut_in[2*W-1:W];
  assign mask     = {W{1'b1}} << s_op;
  assign golden   = (t_op < mask);
  assign mismatch = (golden != fut_out);
  assign last_vec = &fut_in;
  assign wait_end = (wait_cnt == CW'(LAT));

  // NOTE: state and datapath registers use non-blocking assignments and an async reset
  // so every flop updates from pre-edge values and reset needs no clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = DRIVE;
      DRIVE:  if (wait_end) state_nxt = SAMPLE;
`ifdef SKOLEM_STOP_ON_FAIL_EN
      SAMPLE: state_nxt = (last_vec || mismatch) ? DONE : DRIVE;
`else
      SAMPLE: state_nxt = last_vec ? DONE : DRIVE;
`endif
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      DRIVE, SAMPLE: busy = 1'b1;
      DONE:          done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fut_in     <= '0;
      fail_cnt   <= '0;
      first_fail <= '0;
      fail_seen  <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (start) begin
            fut_in     <= '0;
            fail_cnt   <= '0;
            first_fail <= '0;
            fail_seen  <= 1'b0;
          end
        end
        DRIVE: wait_cnt <= wait_end ? '0 : wait_cnt + 1'b1;
        SAMPLE: begin
          if (mismatch) begin
            fail_cnt <= fail_cnt + 1'b1;
            if (!fail_seen) begin
              first_fail <= fut_in;
              fail_seen  <= 1'b1;
            end
          end
          // The counter advances only when another vector follows; it never wraps mid-sweep.
          if (state_nxt == DRIVE) fut_in <= fut_in + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_skolem_ic_sweep_ctrl.sv
// Bench for skolem_ic_sweep_ctrl: a LAT=0 and a LAT=2 instance, a brute-force IC model,
// and a scoreboard of expected sweep results pushed at start and popped at done.
module tb_skolem_ic_sweep_ctrl;
  localparam int W = 4;

  typedef struct {
    logic [2*W:0]   cnt;
    logic [2*W-1:0] first;
    logic           seen;
    int             cycles;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_v      [2];
  logic [2*W-1:0] fut_in_v     [2];
  logic           fut_out_v    [2];
  logic           busy_v       [2];
  logic           done_v       [2];
  logic [2*W:0]   fail_cnt_v   [2];
  logic [2*W-1:0] first_fail_v [2];
  logic           fail_seen_v  [2];
  logic           d1, d2;

  int   mode;
  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  skolem_ic_sweep_ctrl #(.W(W), .LAT(0)) u_lat0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .fut_in(fut_in_v[0]), .fut_out(fut_out_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .fail_cnt(fail_cnt_v[0]),
    .first_fail(first_fail_v[0]), .fail_seen(fail_seen_v[0])
  );

  skolem_ic_sweep_ctrl #(.W(W), .LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .start(start_v[1]), .fut_in(fut_in_v[1]), .fut_out(fut_out_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .fail_cnt(fail_cnt_v[1]),
    .first_fail(first_fail_v[1]), .fail_seen(fail_seen_v[1])
  );

  // Definition-level IC: does some x exist with (x << s) >u t.
  function automatic logic ic_ref(logic [2*W-1:0] v);
    logic [W-1:0] t, s, y;
    t = v[2*W-1:W];
    s = v[W-1:0];
    for (int x = 0; x < (1 << W); x++) begin
      y = W'(x) << s;
      if (y > t) return 1'b1;
    end
    return 1'b0;
  endfunction

  // 0: correct FUT, 1: stuck-at-0, 2: stuck-at-1, 3: correct except vectors with v%7==3.
  function automatic logic fut_model(int m, logic [2*W-1:0] v);
    case (m)
      0:       return ic_ref(v);
      1:       return 1'b0;
      2:       return 1'b1;
      default: return ic_ref(v) ^ ((int'(v) % 7) == 3);
    endcase
  endfunction

  function automatic exp_t expect_for(int m, int lat);
    exp_t e;
    logic [2*W-1:0] v;
    e.cnt = '0; e.first = '0; e.seen = 1'b0;
    e.cycles = (1 << (2*W)) * (lat + 2);
    for (int i = 0; i < (1 << (2*W)); i++) begin
      v = (2*W)'(i);
      if (fut_model(m, v) != ic_ref(v)) begin
        e.cnt = e.cnt + 1'b1;
        if (!e.seen) begin
          e.first = v;
          e.seen  = 1'b1;
        end
`ifdef SKOLEM_STOP_ON_FAIL_EN
        e.cycles = (i + 1) * (lat + 2);
        break;
`endif
      end
    end
    return e;
  endfunction

  always_comb fut_out_v[0] = fut_model(mode, fut_in_v[0]);

  always @(posedge clk) begin
    d1 <= fut_model(mode, fut_in_v[1]);
    d2 <= d1;
  end
  assign fut_out_v[1] = d2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input int w, input string tag);
    check({tag, ".fut_in"},     64'(fut_in_v[w]),     64'h0);
    check({tag, ".busy"},       64'(busy_v[w]),       64'h0);
    check({tag, ".done"},       64'(done_v[w]),       64'h0);
    check({tag, ".fail_cnt"},   64'(fail_cnt_v[w]),   64'h0);
    check({tag, ".first_fail"}, 64'(first_fail_v[w]), 64'h0);
    check({tag, ".fail_seen"},  64'(fail_seen_v[w]),  64'h0);
  endtask

  // One full sweep on instance w; optionally pulses start while busy at cycle poke_at.
  task automatic sweep(input int w, input int m, input int poke_at, input string tag);
    exp_t e;
    int   cycles;
    mode = m;
    sb_q.push_back(expect_for(m, (w == 0) ? 0 : 2));
    @(negedge clk); start_v[w] = 1'b1;
    @(negedge clk); start_v[w] = 1'b0;
    check({tag, ".busy_on_start"}, 64'(busy_v[w]),     64'h1);
    check({tag, ".fut_in_start"},  64'(fut_in_v[w]),   64'h0);
    check({tag, ".cnt_cleared"},   64'(fail_cnt_v[w]), 64'h0);
    cycles = 0;
    while (!done_v[w] && cycles < 3000) begin
      start_v[w] = (cycles == poke_at);
      @(negedge clk);
      cycles++;
    end
    start_v[w] = 1'b0;
    e = sb_q.pop_front();
    check({tag, ".done_seen"},  64'(done_v[w]),       64'h1);
    check({tag, ".cycles"},     64'(cycles),          64'(e.cycles));
    check({tag, ".fail_cnt"},   64'(fail_cnt_v[w]),   64'(e.cnt));
    check({tag, ".first_fail"}, 64'(first_fail_v[w]), 64'(e.first));
    check({tag, ".fail_seen"},  64'(fail_seen_v[w]),  64'(e.seen));
    check({tag, ".busy_at_done"}, 64'(busy_v[w]),     64'h0);
    // start in the done cycle must be ignored
    start_v[w] = 1'b1;
    @(negedge clk); start_v[w] = 1'b0;
    check({tag, ".done_pulse"}, 64'(done_v[w]), 64'h0);
    check({tag, ".no_restart"}, 64'(busy_v[w]), 64'h0);
    @(negedge clk);
    check({tag, ".idle_hold_busy"}, 64'(busy_v[w]),     64'h0);
    check({tag, ".idle_hold_cnt"},  64'(fail_cnt_v[w]), 64'(e.cnt));
  endtask

  initial begin
    int n;
    mode = 0;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero(0, "reset_lat0");
    check_zero(1, "reset_lat2");
    rst = 1'b0;

    sweep(0, 0, 100, "golden_lat0");
    sweep(0, 1, -1,  "stuck0_lat0");
    sweep(0, 2, 37,  "stuck1_lat0");
    sweep(0, 3, -1,  "sparse_lat0");
    sweep(1, 0, 200, "golden_lat2");
    sweep(1, 3, -1,  "sparse_lat2");

    // Abort mid-sweep with an asynchronous reset, then restart from vector 0.
    mode = 1;
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    n = 0;
    while (fut_in_v[0] != 8'h37 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("abort.reach_37", 64'(fut_in_v[0]), 64'h37);
    #2 rst = 1'b1;
    #1 check_zero(0, "abort_async");
    @(negedge clk); rst = 1'b0;
    sweep(0, 1, -1, "restart_lat0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
